// File: rtl/dma_io_device.sv
// DMA request/acknowledge handshake engine: single (gapped) or demand-mode
// transfer blocks with runtime pin polarity, Dack timeout and spurious-ack flag.
module dma_io_device #(
  parameter int HOLDOFF      = 2,
  parameter int DACK_TIMEOUT = 10
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       Start,
  input  logic [7:0] Count,
  input  logic       Demand,
  input  logic       SenseDreq,
  input  logic       SenseDack,
  input  logic       Dack,
  input  logic       Eop_n,
  output logic       Dreq,
  output logic       Busy,
  output logic       Done,
  output logic       Error,
  output logic       Spurious,
  output logic [7:0] XferCount
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_GAP  = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam logic [3:0] GAP_LOAD  = 4'(HOLDOFF);
  localparam logic [7:0] TMO_LIMIT = 8'(DACK_TIMEOUT);

  state_t     state_r, state_s;
  logic [7:0] remaining_r, remaining_s;
  logic [7:0] xfer_r, xfer_s;
  logic [7:0] tmo_r, tmo_s;
  logic [3:0] gap_r, gap_s;
  logic       error_r, error_s;
  logic       spurious_r, spurious_s;

  logic       req_s;
  logic       ack_s;
  logic       start_ok_s;
  logic [7:0] tmo_inc_s;

  // Pin polarity translation stays combinational so a sense change acts at once.
  assign req_s = (state_r == S_REQ);
  assign ack_s = SenseDack ? Dack : ~Dack;
  assign Dreq  = SenseDreq ? ~req_s : req_s;

  assign start_ok_s = Start && (Count != 8'd0) &&
                      ((state_r == S_IDLE) || (state_r == S_DONE) || (state_r == S_ERR));
  assign tmo_inc_s  = tmo_r + 8'd1;

  assign Busy      = (state_r != S_IDLE);
  assign Done      = (state_r == S_DONE);
  assign Error     = error_r;
  assign Spurious  = spurious_r;
  assign XferCount = xfer_r;

  // Next-state and datapath update logic.
  always_comb begin
    state_s     = state_r;
    remaining_s = remaining_r;
    xfer_s      = xfer_r;
    tmo_s       = tmo_r;
    gap_s       = gap_r;
    error_s     = error_r;
    spurious_s  = spurious_r;

    if (ack_s && (state_r != S_REQ)) begin
      spurious_s = 1'b1;
    end else begin
      spurious_s = spurious_r;
    end

    case (state_r)
      S_IDLE: begin
        state_s = S_IDLE;
      end
      S_REQ: begin
        if (ack_s) begin
          remaining_s = remaining_r - 8'd1;
          xfer_s      = xfer_r + 8'd1;
          tmo_s       = 8'd0;
          if (!Eop_n || (remaining_r <= 8'd1)) begin
            state_s = S_DONE;
          end else if (Demand) begin
            state_s = S_REQ;
          end else begin
            state_s = S_GAP;
            gap_s   = GAP_LOAD;
          end
        end else begin
          tmo_s = tmo_inc_s;
          if (tmo_inc_s >= TMO_LIMIT) begin
            state_s = S_ERR;
            error_s = 1'b1;
          end else begin
            state_s = S_REQ;
          end
        end
      end
      S_GAP: begin
        if (gap_r <= 4'd1) begin
          state_s = S_REQ;
          gap_s   = 4'd0;
        end else begin
          state_s = S_GAP;
          gap_s   = gap_r - 4'd1;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      S_ERR: begin
        state_s = S_ERR;
        error_s = 1'b1;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    // An accepted Start only arises in IDLE/DONE/ERR and overrides those arms.
    if (start_ok_s) begin
      state_s     = S_REQ;
      remaining_s = Count;
      xfer_s      = 8'd0;
      tmo_s       = 8'd0;
      gap_s       = 4'd0;
      error_s     = 1'b0;
      spurious_s  = 1'b0;
    end else begin
      state_s = state_s;
    end
  end

  // State and counter registers.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r     <= S_IDLE;
      remaining_r <= 8'd0;
      xfer_r      <= 8'd0;
      tmo_r       <= 8'd0;
      gap_r       <= 4'd0;
      error_r     <= 1'b0;
      spurious_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      remaining_r <= remaining_s;
      xfer_r      <= xfer_s;
      tmo_r       <= tmo_s;
      gap_r       <= gap_s;
      error_r     <= error_s;
      spurious_r  <= spurious_s;
    end
  end

endmodule

// File: doc/dma_io_device.md
DMA_IO_DEVICE -- requirements
Module: dma_io_device

Interface
REQ-001 Parameter HOLDOFF, default 2: idle cycles between single-mode requests (range 1-15).
REQ-002 Parameter DACK_TIMEOUT, default 10: cycles to wait for Dack before the block flags an error (range 1-255).
REQ-003 Clock  in  1  the single clock; all state changes on its rising edge.
REQ-004 Reset_n  in  1  asynchronous, active-low reset.
REQ-005 Start  in  1  one-cycle request to begin a transfer block.
REQ-006 Count  in  8  number of transfers in the block, sampled on an accepted Start.
REQ-007 Demand  in  1  transfer mode: 0 = single mode, 1 = demand mode.
REQ-008 SenseDreq  in  1  Dreq polarity: 0 = active high, 1 = active low.
REQ-009 SenseDack  in  1  Dack polarity: 0 = active low, 1 = active high.
REQ-010 Dack  in  1  raw acknowledge pin from the DMA controller.
REQ-011 Eop_n  in  1  active-low end-of-process from the controller.
REQ-012 Dreq  out  1  raw request pin to the DMA controller.
REQ-013 Busy  out  1  high in any state other than IDLE.
REQ-014 Done  out  1  one-cycle pulse when a block completes or is terminated.
REQ-015 Error  out  1  Dack timeout flag, sticky until the next accepted Start.
REQ-016 Spurious  out  1  sticky flag: Dack was seen active while the block was not requesting; cleared on an accepted Start.
REQ-017 XferCount  out  8  number of transfers completed in the current or last block.

Function
REQ-018 The block SHALL implement the states IDLE, REQ, GAP, DONE and ERR.
REQ-019 Internal request level: req = 1 in REQ, 0 otherwise.
REQ-020 Dreq SHALL equal SenseDreq ? ~req : req.
REQ-021 Internal acknowledge: ack = SenseDack ? Dack : ~Dack.
REQ-022 Start is accepted only in IDLE, ERR or DONE, and only with Count != 0.
REQ-023 On an accepted Start, the block loads remaining = Count and clears XferCount, Error, Spurious and the timeout counter.
REQ-024 On an accepted Start, the next state SHALL be REQ.
REQ-025 Start with Count == 0, or Start in REQ or GAP, SHALL be ignored with no state change.
REQ-026 In REQ, each rising edge with ack = 1 counts one transfer: remaining decrements, XferCount increments, and the timeout counter clears.
REQ-027 In REQ with ack = 1 and Eop_n = 0: the transfer is counted, then next state = DONE regardless of remaining.
REQ-028 In REQ with ack = 1 and remaining == 1: next state = DONE.
REQ-029 In REQ with ack = 1, remaining > 1 and Demand = 0: next state = GAP, with the GAP counter loaded to HOLDOFF.
REQ-030 In REQ with ack = 1, remaining > 1 and Demand = 1: the block stays in REQ and Dreq stays asserted with no gap.
REQ-031 In REQ with ack = 0: the timeout counter increments; when it reaches DACK_TIMEOUT, next state = ERR.
REQ-032 GAP: the counter decrements each cycle; at 1, next state = REQ. Dack and Eop_n are ignored apart from the Spurious check.
REQ-033 DONE SHALL last one cycle with Done = 1, then go to IDLE unless Start is accepted that same cycle.
REQ-034 ERR: Error = 1 and Dreq is inactive; the block leaves ERR only on an accepted Start.
REQ-035 ack = 1 in IDLE, GAP, DONE or ERR SHALL set Spurious; the transfer is not counted.
REQ-036 A change of SenseDreq or SenseDack mid-block takes effect combinationally; the state is not affected.
REQ-037 Dreq deasserts on the clock edge that captures the last transfer (latency 0 cycles after the Dack edge).

Reset
REQ-038 Reset_n = 0 SHALL force IDLE immediately and asynchronously, from any state including mid-block.
REQ-039 During reset, req = 0, so Dreq sits at the inactive level for the current SenseDreq.
REQ-040 During reset, Busy = 0, Done = 0, Error = 0, Spurious = 0 and XferCount = 0.
REQ-041 During reset, the remaining, timeout and gap counters SHALL be 0.
REQ-042 After Reset_n rises, the first accepted Start is honoured on the next rising edge.

Verification
REQ-043 Single mode: Count = 3, Demand = 0, Sense = 0/0, Dack low for 1 cycle on each request -> three Dreq pulses separated by 2 idle cycles, XferCount = 3, one Done pulse, Error = 0.
REQ-044 Demand mode: Count = 4, Demand = 1, Dack held low -> Dreq high for exactly 4 cycles, XferCount = 4, Done one cycle after the last transfer.
REQ-045 Early EOP: Count = 10, Demand = 1, Eop_n = 0 on the 3rd acknowledged cycle -> XferCount = 3, Done pulse, Dreq inactive on the next cycle.
REQ-046 Timeout: Count = 2, Dack never asserted -> ERR after 10 cycles, Error = 1, Dreq inactive; a subsequent Start clears Error and re-requests.
REQ-047 Polarity and spurious: SenseDreq = 1, SenseDack = 1 -> Dreq idles high and drops low when requesting; a Dack high pulse in IDLE sets Spurious with XferCount unchanged.
REQ-048 Reset mid-block: Reset_n = 0 during demand-mode REQ -> Dreq goes inactive immediately, all outputs go to 0, and after release the block stays IDLE.
